// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: SPART bus master that programs the baud divisor, arbitrates two TX requesters
// round-robin and drains RX bytes into a valid/ready output register.
module spart_bus_ctrl #(
    parameter logic [15:0] DIV0 = 16'h0515,
    parameter logic [15:0] DIV1 = 16'h028A,
    parameter logic [15:0] DIV2 = 16'h0145,
    parameter logic [15:0] DIV3 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       tx_valid_a,
    input  logic [7:0] tx_data_a,
    output logic       tx_ready_a,
    input  logic       tx_valid_b,
    input  logic [7:0] tx_data_b,
    output logic       tx_ready_b,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);
    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_RD, TX_WR, TX_HOLD} state_t;
    state_t state, state_n;
    logic [7:0] dout, dout_n, tx_byte, tx_byte_n;
    logic [1:0] ioaddr_n, shadow, shadow_n;
    logic [15:0] div_cur, div_sh;
    logic iocs_n, iorw_n, rdy_a_n, rdy_b_n, cfg_done_n, gnt, gnt_n, gnt_sel, rr, rr_n, rd_busy;
    function automatic logic [15:0] div_of(input logic [1:0] c);
        return c == 2'd0 ? DIV0 : c == 2'd1 ? DIV1 : c == 2'd2 ? DIV2 : DIV3;
    endfunction
    assign div_cur = div_of(br_cfg);
    assign div_sh  = div_of(shadow);
    assign gnt_sel = (tx_valid_a && tx_valid_b) ? rr : tx_valid_b;
    // A read registered last cycle is on the bus now; hold decisions until it lands.
    assign rd_busy = iocs && iorw;
    assign databus = (iocs && !iorw) ? dout : 8'bz;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= CFG_LO;
            iocs       <= 1'b0;
            iorw       <= 1'b1;
            ioaddr     <= 2'b00;
            dout       <= 8'h00;
            tx_ready_a <= 1'b0;
            tx_ready_b <= 1'b0;
            cfg_done   <= 1'b0;
            shadow     <= 2'b00;
            gnt        <= 1'b0;
            tx_byte    <= 8'h00;
            rr         <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            iocs       <= iocs_n;
            iorw       <= iorw_n;
            ioaddr     <= ioaddr_n;
            dout       <= dout_n;
            tx_ready_a <= rdy_a_n;
            tx_ready_b <= rdy_b_n;
            cfg_done   <= cfg_done_n;
            shadow     <= shadow_n;
            gnt        <= gnt_n;
            tx_byte    <= tx_byte_n;
            rr         <= rr_n;
            if (rd_busy) begin
                rx_data  <= databus;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
        end
    always_comb begin
        state_n    = state;
        iocs_n     = 1'b0;
        iorw_n     = 1'b1;
        ioaddr_n   = 2'b00;
        dout_n     = dout;
        rdy_a_n    = 1'b0;
        rdy_b_n    = 1'b0;
        cfg_done_n = cfg_done;
        shadow_n   = shadow;
        gnt_n      = gnt;
        tx_byte_n  = tx_byte;
        rr_n       = rr;
        case (state)
            CFG_LO: begin
                iocs_n   = 1'b1;
                iorw_n   = 1'b0;
                ioaddr_n = 2'b10;
                dout_n   = div_cur[7:0];
                shadow_n = br_cfg;
                state_n  = CFG_HI;
            end
            CFG_HI: begin
                iocs_n     = 1'b1;
                iorw_n     = 1'b0;
                ioaddr_n   = 2'b11;
                dout_n     = div_sh[15:8];
                cfg_done_n = 1'b1;
                state_n    = IDLE;
            end
            IDLE:
                if (!rd_busy) begin
                    if (br_cfg != shadow) begin
                        cfg_done_n = 1'b0;
                        state_n    = CFG_LO;
                    end else if (cfg_done && rda && !rx_valid)
                        state_n = RX_RD;
                    else if (cfg_done && tbr && (tx_valid_a || tx_valid_b)) begin
                        gnt_n     = gnt_sel;
                        tx_byte_n = gnt_sel ? tx_data_b : tx_data_a;
                        state_n   = TX_WR;
                    end
                end
            RX_RD: begin
                iocs_n  = 1'b1;
                state_n = IDLE;
            end
            TX_WR: begin
                iocs_n  = 1'b1;
                iorw_n  = 1'b0;
                dout_n  = tx_byte;
                rdy_a_n = !gnt;
                rdy_b_n = gnt;
                rr_n    = !gnt;
                state_n = TX_HOLD;
            end
            TX_HOLD: state_n = IDLE;
            default: state_n = CFG_LO;
        endcase
    end
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl: directed checks of configuration, TX arbitration, RX backpressure,
// access priority, reconfiguration after TX and reset during configuration.
module tb_spart_bus_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic tx_valid_a = 1'b0, tx_valid_b = 1'b0, rx_ready = 1'b0, rda = 1'b0, tbr = 1'b0;
    logic [7:0] tx_data_a = 8'h00, tx_data_b = 8'h00, spart_rd = 8'h00;
    logic tx_ready_a, tx_ready_b, rx_valid, cfg_done, iocs, iorw;
    logic [7:0] rx_data;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    int n_chk = 0, n_fail = 0;

    assign databus = (iocs && iorw) ? spart_rd : 8'bz;
    always #5 clk = ~clk;

    spart_bus_ctrl dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg),
        .tx_valid_a(tx_valid_a), .tx_data_a(tx_data_a), .tx_ready_a(tx_ready_a),
        .tx_valid_b(tx_valid_b), .tx_data_b(tx_data_b), .tx_ready_b(tx_ready_b),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .cfg_done(cfg_done),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (iocs !== 1'b0) begin n_fail++; $display("FAIL reset_iocs got %b want 0", iocs); end
        n_chk++; if (iorw !== 1'b1) begin n_fail++; $display("FAIL reset_iorw got %b want 1", iorw); end
        n_chk++; if (ioaddr !== 2'b00) begin n_fail++; $display("FAIL reset_ioaddr got %b want 00", ioaddr); end
        n_chk++; if ({tx_ready_a, tx_ready_b} !== 2'b00) begin n_fail++; $display("FAIL reset_tx_ready got %b%b want 00", tx_ready_a, tx_ready_b); end
        n_chk++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got %b/%h want 0/00", rx_valid, rx_data); end
        n_chk++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done got %b want 0", cfg_done); end
    endtask

    task automatic test_cfg;
        @(negedge clk) rst = 1'b0;
        tick;
        n_chk++; if ({iocs, iorw, ioaddr, databus, cfg_done} !== {1'b1, 1'b0, 2'b10, 8'h8A, 1'b0})
            begin n_fail++; $display("FAIL cfg_lo got cs%b rw%b a%b d%h done%b want cs1 rw0 a10 d8a done0", iocs, iorw, ioaddr, databus, cfg_done); end
        tick;
        n_chk++; if ({iocs, iorw, ioaddr, databus, cfg_done} !== {1'b1, 1'b0, 2'b11, 8'h02, 1'b1})
            begin n_fail++; $display("FAIL cfg_hi got cs%b rw%b a%b d%h done%b want cs1 rw0 a11 d02 done1", iocs, iorw, ioaddr, databus, cfg_done); end
        tick;
        n_chk++; if (iocs !== 1'b0 || cfg_done !== 1'b1) begin n_fail++; $display("FAIL cfg_idle got cs%b done%b want cs0 done1", iocs, cfg_done); end
    endtask

    task automatic test_tx_rr;
        logic [7:0] wq[$];
        int na = 0, nb = 0, last = -10;
        tbr = 1'b1; tx_data_a = 8'h55; tx_data_b = 8'hAA; tx_valid_a = 1'b1; tx_valid_b = 1'b1;
        for (int c = 0; c < 40 && wq.size() < 3; c++) begin
            tick;
            if (tx_ready_a) na++;
            if (tx_ready_b) nb++;
            if (iocs && !iorw && ioaddr == 2'b00) begin
                wq.push_back(databus);
                n_chk++; if (tx_ready_a !== (databus == 8'h55) || tx_ready_b !== (databus == 8'hAA))
                    begin n_fail++; $display("FAIL tx_ready_pair data %h got a%b b%b", databus, tx_ready_a, tx_ready_b); end
                n_chk++; if (c - last < 2) begin n_fail++; $display("FAIL tx_hold_gap got %0d cycles want >=2", c - last); end
                last = c;
            end
        end
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        repeat (6) begin
            tick;
            if (tx_ready_a) na++;
            if (tx_ready_b) nb++;
            if (iocs && !iorw) wq.push_back(databus);
        end
        n_chk++; if (wq.size() != 3) begin n_fail++; $display("FAIL tx_count got %0d want 3", wq.size()); end
        n_chk++; if (wq[0] !== 8'h55 || wq[1] !== 8'hAA || wq[2] !== 8'h55)
            begin n_fail++; $display("FAIL tx_order got %h %h %h want 55 aa 55", wq[0], wq[1], wq[2]); end
        n_chk++; if (na != 2 || nb != 1) begin n_fail++; $display("FAIL tx_pulses got a%0d b%0d want a2 b1", na, nb); end
    endtask

    task automatic test_rx_backpressure;
        int nr = 0;
        tbr = 1'b0; spart_rd = 8'h99; rda = 1'b1; rx_ready = 1'b0;
        for (int c = 0; c < 20 && !rx_valid; c++) begin tick; if (iocs && iorw) nr++; end
        n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin n_fail++; $display("FAIL rx_first got %b/%h want 1/99", rx_valid, rx_data); end
        n_chk++; if (nr != 1) begin n_fail++; $display("FAIL rx_one_read got %0d want 1", nr); end
        repeat (6) begin tick; if (iocs && iorw) nr++; end
        n_chk++; if (nr != 1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_stall got reads%0d valid%b want 1/1", nr, rx_valid); end
        spart_rd = 8'h3C; rx_ready = 1'b1;
        tick;
        if (iocs && iorw) nr++;
        rx_ready = 1'b0;
        n_chk++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_clear got %b want 0", rx_valid); end
        for (int c = 0; c < 20 && !rx_valid; c++) begin tick; if (iocs && iorw) nr++; end
        n_chk++; if (rx_data !== 8'h3C || nr != 2) begin n_fail++; $display("FAIL rx_second got %h reads%0d want 3c reads2", rx_data, nr); end
        rda = 1'b0; rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
    endtask

    task automatic test_priority;
        int c;
        rda = 1'b1; spart_rd = 8'h11; tbr = 1'b1; tx_data_a = 8'h77; tx_valid_a = 1'b1;
        for (c = 0; c < 10 && !iocs; c++) tick;
        n_chk++; if (iocs !== 1'b1 || iorw !== 1'b1 || ioaddr !== 2'b00)
            begin n_fail++; $display("FAIL prio_first got cs%b rw%b a%b want cs1 rw1 a00", iocs, iorw, ioaddr); end
        rda = 1'b0;
        for (c = 0; c < 20 && !(iocs && !iorw); c++) tick;
        n_chk++; if (!(iocs && !iorw) || databus !== 8'h77 || tx_ready_a !== 1'b1)
            begin n_fail++; $display("FAIL prio_tx got cs%b rw%b d%h rdy%b want cs1 rw0 d77 rdy1", iocs, iorw, databus, tx_ready_a); end
        tx_valid_a = 1'b0;
        n_chk++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_fail++; $display("FAIL prio_rx got %b/%h want 1/11", rx_valid, rx_data); end
        rx_ready = 1'b1;
        tick;
        rx_ready = 1'b0;
        tick;
    endtask

    task automatic test_cfg_change;
        logic [9:0] wq[$];
        int na = 0, nlow = 0;
        tbr = 1'b1; tx_data_a = 8'h5A; tx_valid_a = 1'b1;
        tick;
        br_cfg = 2'b11;
        repeat (12) begin
            tick;
            if (tx_ready_a) begin na++; tx_valid_a = 1'b0; end
            if (!cfg_done) nlow++;
            if (iocs && !iorw) wq.push_back({ioaddr, databus});
        end
        n_chk++; if (wq.size() != 3 || wq[0] !== {2'b00, 8'h5A} || wq[1] !== {2'b10, 8'hA2} || wq[2] !== {2'b11, 8'h00})
            begin n_fail++; $display("FAIL recfg_seq got n%0d %h %h %h want 05a 2a2 300", wq.size(), wq[0], wq[1], wq[2]); end
        n_chk++; if (nlow != 2) begin n_fail++; $display("FAIL recfg_done_low got %0d want 2", nlow); end
        n_chk++; if (na != 1) begin n_fail++; $display("FAIL recfg_pulse got %0d want 1", na); end
        tbr = 1'b0;
    endtask

    task automatic test_reset_mid;
        br_cfg = 2'b10;
        for (int c = 0; c < 10 && !(iocs && ioaddr == 2'b10); c++) tick;
        n_chk++; if (!(iocs && ioaddr == 2'b10) || databus !== 8'h45)
            begin n_fail++; $display("FAIL rstmid_lo got cs%b a%b d%h want cs1 a10 d45", iocs, ioaddr, databus); end
        rst = 1'b1;
        #1;
        n_chk++; if (iocs !== 1'b0 || cfg_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_release got cs%b done%b want 0/0", iocs, cfg_done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick;
        n_chk++; if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b0, 2'b10, 8'h45})
            begin n_fail++; $display("FAIL rstmid_redo_lo got cs%b rw%b a%b d%h want cs1 rw0 a10 d45", iocs, iorw, ioaddr, databus); end
        tick;
        n_chk++; if ({iocs, iorw, ioaddr, databus, cfg_done} !== {1'b1, 1'b0, 2'b11, 8'h01, 1'b1})
            begin n_fail++; $display("FAIL rstmid_redo_hi got cs%b rw%b a%b d%h done%b want cs1 rw0 a11 d01 done1", iocs, iorw, ioaddr, databus, cfg_done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_cfg;
        test_tx_rr;
        test_rx_backpressure;
        test_priority;
        test_cfg_change;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spart_bus_ctrl.md
Name: spart_bus_ctrl

Overview:
- Bus master for the SPART register interface (iocs/iorw/ioaddr/databus, rda/tbr status).
- Programs the baud divisor from br_cfg.
- Shares the transmit buffer between two byte requesters (A, B) with round-robin arbitration.
- Drains received bytes into a one-entry output register with valid/ready backpressure.
- Sits between the SPART and on-chip clients, replacing the ad-hoc echo driver.

Parameters:
- DIV0, 16'h0515, divisor for br_cfg=00 (4800 baud @100 MHz, 16x oversample)
- DIV1, 16'h028A, divisor for br_cfg=01 (9600)
- DIV2, 16'h0145, divisor for br_cfg=10 (19200)
- DIV3, 16'h00A2, divisor for br_cfg=11 (38400)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- br_cfg  in  2  baud select
- tx_valid_a  in  1  requester A has byte
- tx_data_a  in  8  requester A byte
- tx_ready_a  out  1  A byte accepted this cycle
- tx_valid_b  in  1  requester B has byte
- tx_data_b  in  8  requester B byte
- tx_ready_b  out  1  B byte accepted this cycle
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer takes rx_data when rx_valid&rx_ready
- cfg_done  out  1  divisor programmed for current br_cfg
- iocs  out  1  SPART chip select
- iorw  out  1  1=read, 0=write
- ioaddr  out  2  00 TX/RX buf, 01 status, 10 DB low, 11 DB high
- databus  inout  8  driven only when iocs=1 && iorw=0, else 'z
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready

Behaviour:
- Reset values: iocs=0, iorw=1, ioaddr=00, databus='z, tx_ready_a/b=0, rx_valid=0, rx_data=8'h00, cfg_done=0, state=CFG_LO, rr pointer=A, br_cfg shadow=00.
- All bus outputs are registered; each bus access is one cycle with iocs=1.
- States:
  - CFG_LO: write DIVn[7:0] to ioaddr 10, latch br_cfg into shadow; next CFG_HI.
  - CFG_HI: write DIVn[15:8] to ioaddr 11; set cfg_done=1; next IDLE.
  - IDLE: choose next access with priority config > RX > TX.
    - br_cfg != shadow: cfg_done=0 the next cycle; goto CFG_LO.
    - else rda=1 and rx_valid=0: goto RX_RD.
    - else tbr=1 and any tx_valid: goto TX_WR.
  - RX_RD: iocs=1, iorw=1, ioaddr=00; sample databus at the closing edge into rx_data; set rx_valid=1; next IDLE.
  - TX_WR: write the granted byte to ioaddr 00; pulse the granted tx_ready for exactly this cycle; rr pointer moves to the other requester; next TX_HOLD.
  - TX_HOLD: one idle cycle, tbr ignored (SPART needs it to deassert tbr); next IDLE.
- Arbitration:
  - Only one of A/B valid: it is granted.
  - Both valid: grant the rr pointer; pointer updates only on a grant.
  - Grant and byte are captured on entry to TX_WR. tx_valid must be held until tx_ready.
- RX backpressure:
  - With rx_valid=1, no read is issued; the byte waits in the SPART (rda stays 1).
  - rx_valid clears on the cycle after the rx_valid&rx_ready handshake.
  - A handshake and a new RX_RD landing the same edge: the new byte wins and rx_valid stays 1.
- br_cfg change mid-TX_WR/TX_HOLD/RX_RD: the current access completes, then reconfiguration. The tx_ready pulse is never dropped or duplicated.
- Reset mid-operation: immediate return to reset values; the bus releases asynchronously (iocs=0, databus='z).
- cfg_done low: no TX or RX access is issued.

Test Plan:
- Release rst with br_cfg=01:
  - cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h8A
  - cycle 2: ioaddr=11, databus=8'h02
  - cfg_done=1 thereafter; databus='z when idle.
- tx_valid_a=1 with 8'h55 and tx_valid_b=1 with 8'hAA held, tbr=1:
  - writes to ioaddr 00 in order 55, AA, 55, with one TX_HOLD cycle between each.
  - exactly one tx_ready pulse per write.
- rda=1 with SPART returning 8'h99, rx_ready=0:
  - one read; rx_data=99, rx_valid=1.
  - no further read while rda stays 1.
  - rx_ready=1 then clears rx_valid, and the next read follows.
- rda=1, tbr=1, tx_valid_a=1 the same cycle: RX_RD is issued before TX_WR.
- br_cfg 01->11 during TX_WR:
  - the write completes, then CFG_LO/CFG_HI write A2/00.
  - cfg_done low for those 2 cycles.
- rst asserted during CFG_HI: iocs=0 within the same cycle; after release, the full CFG_LO/CFG_HI sequence repeats.
